// File: rtl/modulo_corrector_error.sv
// -----------------------------------------------------------------------------
// modulo_corrector_error
// Registered SECDED Hamming(8,4) correction stage, placed right after the
// syndrome/parity detector. It takes the received codeword together with the
// detector's syndrome, global parity and double-error flag, flips the single
// faulty bit, extracts the 4 data bits and presents the result on a
// valid/ready output. It also keeps saturating counts of single and double
// errors. A double error locks the stream until limpiar_error is pulsed.
//
// Ports
//   clk               single clock, all state updates on the rising edge
//   rst               synchronous, active-high reset
//   entrada_valida    upstream word and detector outputs are valid
//   entrada_lista     stage can accept a word
//   datos_recibidos   codeword: bit i = Hamming position i+1, bit 7 = p0
//   sindrome          faulty Hamming position (0 = none)
//   paridad_global    XOR of all 8 received bits
//   error_doble       detector double-error flag
//   limpiar_error     one-cycle pulse that releases the BLOQUEO state
//   salida_valida     palabra/datos outputs are valid
//   salida_lista      downstream accepts the output word
//   palabra_corregida corrected codeword
//   datos_corregidos  {d4,d3,d2,d1} of the corrected codeword
//   error_corregido   held word had a single error fixed (including p0)
//   bloqueado         high while in BLOQUEO
//   cont_simples      saturating count of accepted single-error words
//   cont_dobles       saturating count of double errors
//   estado            current FSM state (debug visibility)
//
// Handshake: a word moves on a rising edge where valid and ready are both
// high on that interface. A producer holds valid and its data stable until
// the transfer; ready never depends on valid on the same interface. Here,
// entrada_lista follows salida_lista combinationally while a word is held,
// so a word can leave and a new one enter on the same edge.
// -----------------------------------------------------------------------------
module modulo_corrector_error #(
    parameter int ANCHO_CONT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  entrada_valida,
    output logic                  entrada_lista,
    input  logic [7:0]            datos_recibidos,
    input  logic [2:0]            sindrome,
    input  logic                  paridad_global,
    input  logic                  error_doble,
    input  logic                  limpiar_error,
    output logic                  salida_valida,
    input  logic                  salida_lista,
    output logic [7:0]            palabra_corregida,
    output logic [3:0]            datos_corregidos,
    output logic                  error_corregido,
    output logic                  bloqueado,
    output logic [ANCHO_CONT-1:0] cont_simples,
    output logic [ANCHO_CONT-1:0] cont_dobles,
    output logic [1:0]            estado
);

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        LLENO   = 2'd1,
        BLOQUEO = 2'd2
    } estado_t;

    localparam logic [ANCHO_CONT-1:0] CONT_UNO = 1;
    localparam logic [ANCHO_CONT-1:0] CONT_MAX = '1;

    estado_t               estado_q, estado_d;
    logic [7:0]            palabra_q, palabra_d;
    logic                  err_q, err_d;
    logic [ANCHO_CONT-1:0] simples_q, simples_d;
    logic [ANCHO_CONT-1:0] dobles_q, dobles_d;
    logic [7:0]            mascara;
    logic                  cargar;

    // Bit to flip. An odd global parity with a zero syndrome means only p0
    // (bit 7) is wrong; a non-zero syndrome names Hamming position s, which
    // lives in bit s-1.
    always_comb begin
        mascara = 8'h00;
        if (paridad_global) begin
            if (sindrome != 3'd0) begin
                mascara = 8'd1 << (sindrome - 3'd1);
            end else begin
                mascara = 8'h80;
            end
        end
    end

    always_comb begin
        estado_d      = estado_q;
        palabra_d     = palabra_q;
        err_d         = err_q;
        simples_d     = simples_q;
        dobles_d      = dobles_q;
        entrada_lista = 1'b0;
        salida_valida = 1'b0;
        bloqueado     = 1'b0;
        cargar        = 1'b0;

        case (estado_q)
            ESPERA: begin
                entrada_lista = !rst;
                cargar        = entrada_valida;
            end
            LLENO: begin
                salida_valida = 1'b1;
                entrada_lista = salida_lista && !rst;
                // Output leaves this edge; a new word may replace it.
                if (salida_lista) begin
                    estado_d = ESPERA;
                    cargar   = entrada_valida;
                end
            end
            BLOQUEO: begin
                bloqueado = 1'b1;
                if (limpiar_error) begin
                    estado_d = ESPERA;
                end
            end
            default: begin
                estado_d = ESPERA;
            end
        endcase

        if (cargar) begin
            if (error_doble) begin
                // Uncorrectable word is dropped and the stream locks.
                estado_d = BLOQUEO;
                if (dobles_q != CONT_MAX) begin
                    dobles_d = dobles_q + CONT_UNO;
                end
            end else begin
                estado_d  = LLENO;
                palabra_d = datos_recibidos ^ mascara;
                err_d     = paridad_global;
                if (paridad_global && (simples_q != CONT_MAX)) begin
                    simples_d = simples_q + CONT_UNO;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= ESPERA;
            palabra_q <= 8'h00;
            err_q     <= 1'b0;
            simples_q <= '0;
            dobles_q  <= '0;
        end else begin
            estado_q  <= estado_d;
            palabra_q <= palabra_d;
            err_q     <= err_d;
            simples_q <= simples_d;
            dobles_q  <= dobles_d;
        end
    end

    assign palabra_corregida = palabra_q;
    assign datos_corregidos  = {palabra_q[6], palabra_q[5], palabra_q[4], palabra_q[2]};
    assign error_corregido   = err_q;
    assign cont_simples      = simples_q;
    assign cont_dobles       = dobles_q;
    assign estado            = estado_q;

endmodule

// File: tb/tb_modulo_corrector_error.sv
// -----------------------------------------------------------------------------
// tb_modulo_corrector_error
// Directed bench for the Hamming(8,4) correction stage. Inputs are driven
// 1 time unit after each rising edge and outputs are read there too; the
// scoreboard samples both handshakes on the falling edge, where the inputs
// for the coming edge are already stable. A second instance with
// ANCHO_CONT=2 shares the stimulus to show counter saturation.
// -----------------------------------------------------------------------------
module tb_modulo_corrector_error;

    typedef struct {
        logic [7:0] rx;
        logic [2:0] sind;
        logic       par;
        logic [7:0] pal;
        logic [3:0] dat;
        logic       err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       entrada_valida;
    logic       entrada_lista;
    logic [7:0] datos_recibidos;
    logic [2:0] sindrome;
    logic       paridad_global;
    logic       error_doble;
    logic       limpiar_error;
    logic       salida_valida;
    logic       salida_lista;
    logic [7:0] palabra_corregida;
    logic [3:0] datos_corregidos;
    logic       error_corregido;
    logic       bloqueado;
    logic [7:0] cont_simples;
    logic [7:0] cont_dobles;
    logic [1:0] estado;

    logic       el_s, sv_s, ec_s, bl_s;
    logic [7:0] pal_s;
    logic [3:0] dat_s;
    logic [1:0] cs_s, cd_s, est_s;

    int checks = 0;
    int errors = 0;
    int exp_simples = 0;
    logic last_in_xfer = 1'b0;
    logic [7:0] exp_pal;
    logic [3:0] exp_dat;
    logic       exp_err;
    logic [12:0] exp_q[$];
    vec_t vecs[12];

    always #5 clk = ~clk;

    modulo_corrector_error #(.ANCHO_CONT(8)) dut (
        .clk(clk), .rst(rst),
        .entrada_valida(entrada_valida), .entrada_lista(entrada_lista),
        .datos_recibidos(datos_recibidos), .sindrome(sindrome),
        .paridad_global(paridad_global), .error_doble(error_doble),
        .limpiar_error(limpiar_error),
        .salida_valida(salida_valida), .salida_lista(salida_lista),
        .palabra_corregida(palabra_corregida), .datos_corregidos(datos_corregidos),
        .error_corregido(error_corregido), .bloqueado(bloqueado),
        .cont_simples(cont_simples), .cont_dobles(cont_dobles),
        .estado(estado)
    );

    modulo_corrector_error #(.ANCHO_CONT(2)) dut_s (
        .clk(clk), .rst(rst),
        .entrada_valida(entrada_valida), .entrada_lista(el_s),
        .datos_recibidos(datos_recibidos), .sindrome(sindrome),
        .paridad_global(paridad_global), .error_doble(error_doble),
        .limpiar_error(limpiar_error),
        .salida_valida(sv_s), .salida_lista(salida_lista),
        .palabra_corregida(pal_s), .datos_corregidos(dat_s),
        .error_corregido(ec_s), .bloqueado(bl_s),
        .cont_simples(cs_s), .cont_dobles(cd_s),
        .estado(est_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock. The scoreboard runs on the falling edge, then the
    // task returns 1 time unit after the next rising edge.
    task automatic next_cycle();
        logic [12:0] e;
        @(negedge clk);
        last_in_xfer = !rst && entrada_valida && entrada_lista;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (salida_valida && salida_lista) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got palabra %0h with no word pending", palabra_corregida);
                end else begin
                    e = exp_q.pop_front();
                    if ({palabra_corregida, datos_corregidos, error_corregido} !== e) begin
                        errors++;
                        $display("FAIL sb_word got pal=%0h dat=%0h err=%0b expected pal=%0h dat=%0h err=%0b",
                                 palabra_corregida, datos_corregidos, error_corregido,
                                 e[12:5], e[4:1], e[0]);
                    end
                end
            end
            if (last_in_xfer && !error_doble) begin
                exp_q.push_back({exp_pal, exp_dat, exp_err});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input logic [7:0] rx, input logic [2:0] s, input logic p,
                            input logic dbl, input logic [7:0] ep, input logic [3:0] ed,
                            input logic ee);
        datos_recibidos = rx;
        sindrome        = s;
        paridad_global  = p;
        error_doble     = dbl;
        exp_pal         = ep;
        exp_dat         = ed;
        exp_err         = ee;
        entrada_valida  = 1'b1;
    endtask

    task automatic idle_inputs();
        entrada_valida  = 1'b0;
        error_doble     = 1'b0;
        datos_recibidos = 8'($urandom_range(0, 255));
        sindrome        = 3'($urandom_range(0, 7));
        paridad_global  = 1'($urandom_range(0, 1));
    endtask

    // Offer one word and wait (bounded) until it is taken.
    task automatic send(input logic [7:0] rx, input logic [2:0] s, input logic p,
                        input logic dbl, input logic [7:0] ep, input logic [3:0] ed,
                        input logic ee);
        int n = 0;
        set_word(rx, s, p, dbl, ep, ed, ee);
        next_cycle();
        while (!last_in_xfer && n < 20) begin
            next_cycle();
            n++;
        end
        checks++;
        if (!last_in_xfer) begin
            errors++;
            $display("FAIL send_accept got no transfer of %0h expected transfer within 20 cycles", rx);
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // rx, sindrome, paridad -> palabra, datos, error_corregido
        vecs[0]  = '{8'h66, 3'd0, 1'b0, 8'h66, 4'hD, 1'b0};
        vecs[1]  = '{8'h76, 3'd5, 1'b1, 8'h66, 4'hD, 1'b1};
        vecs[2]  = '{8'hE6, 3'd0, 1'b1, 8'h66, 4'hD, 1'b1};
        vecs[3]  = '{8'h00, 3'd0, 1'b0, 8'h00, 4'h0, 1'b0};
        vecs[4]  = '{8'hFF, 3'd0, 1'b0, 8'hFF, 4'hF, 1'b0};
        vecs[5]  = '{8'hFE, 3'd1, 1'b1, 8'hFF, 4'hF, 1'b1};
        vecs[6]  = '{8'hC7, 3'd7, 1'b1, 8'h87, 4'h1, 1'b1};
        vecs[7]  = '{8'hD6, 3'd3, 1'b1, 8'hD2, 4'hA, 1'b1};
        vecs[8]  = '{8'h52, 3'd0, 1'b1, 8'hD2, 4'hA, 1'b1};
        vecs[9]  = '{8'h87, 3'd0, 1'b0, 8'h87, 4'h1, 1'b0};
        vecs[10] = '{8'hDA, 3'd4, 1'b1, 8'hD2, 4'hA, 1'b1};
        vecs[11] = '{8'h02, 3'd2, 1'b1, 8'h00, 4'h0, 1'b1};

        // Clock/reset
        rst = 1'b1;
        entrada_valida = 1'b0;
        datos_recibidos = 8'h00;
        sindrome = 3'd0;
        paridad_global = 1'b0;
        error_doble = 1'b0;
        limpiar_error = 1'b0;
        salida_lista = 1'b1;
        exp_pal = 8'h00;
        exp_dat = 4'h0;
        exp_err = 1'b0;
        repeat (2) next_cycle();
        chk("rst_salida_valida", salida_valida, 0);
        chk("rst_entrada_lista", entrada_lista, 0);
        chk("rst_palabra", palabra_corregida, 0);
        chk("rst_err", error_corregido, 0);
        chk("rst_bloqueado", bloqueado, 0);
        chk("rst_cont_simples", cont_simples, 0);
        chk("rst_cont_dobles", cont_dobles, 0);
        rst = 1'b0;
        next_cycle();
        chk("post_rst_entrada_lista", entrada_lista, 1);
        chk("post_rst_estado", estado, 0);

        // Table: one word at a time, output taken the next cycle
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].rx, vecs[i].sind, vecs[i].par, 1'b0,
                 vecs[i].pal, vecs[i].dat, vecs[i].err);
            chk("vec_latency_valid", salida_valida, 1);
            chk("vec_lista_passthru", entrada_lista, 1);
            next_cycle();
            if (vecs[i].err) exp_simples++;
            chk("vec_salida_drained", salida_valida, 0);
            chk("vec_cont_simples", cont_simples, exp_simples);
        end

        // Back-to-back, one word per cycle
        for (int i = 0; i < 4; i++) begin
            set_word(vecs[i].rx, vecs[i].sind, vecs[i].par, 1'b0,
                     vecs[i].pal, vecs[i].dat, vecs[i].err);
            next_cycle();
            chk("b2b_accept", last_in_xfer, 1);
            if (vecs[i].err) exp_simples++;
        end
        idle_inputs();
        next_cycle();
        chk("b2b_queue_empty", exp_q.size(), 0);
        chk("b2b_cont_simples", cont_simples, exp_simples);

        // Double error from ESPERA
        send(8'h65, 3'b011, 1'b0, 1'b1, 8'h00, 4'h0, 1'b0);
        chk("dbl_salida_valida", salida_valida, 0);
        chk("dbl_bloqueado", bloqueado, 1);
        chk("dbl_entrada_lista", entrada_lista, 0);
        chk("dbl_cont_dobles", cont_dobles, 1);
        set_word(8'h66, 3'd0, 1'b0, 1'b0, 8'h66, 4'hD, 1'b0);
        repeat (2) begin
            next_cycle();
            chk("blk_no_accept", last_in_xfer, 0);
            chk("blk_held", bloqueado, 1);
        end
        idle_inputs();
        limpiar_error = 1'b1;
        next_cycle();
        limpiar_error = 1'b0;
        chk("clr_bloqueado", bloqueado, 0);
        chk("clr_entrada_lista", entrada_lista, 1);
        chk("clr_cont_dobles_kept", cont_dobles, 1);

        // Double error arriving while the held word leaves
        send(8'h66, 3'd0, 1'b0, 1'b0, 8'h66, 4'hD, 1'b0);
        send(8'h65, 3'b011, 1'b0, 1'b1, 8'h00, 4'h0, 1'b0);
        chk("dbl2_bloqueado", bloqueado, 1);
        chk("dbl2_salida_valida", salida_valida, 0);
        chk("dbl2_cont_dobles", cont_dobles, 2);
        limpiar_error = 1'b1;
        next_cycle();
        limpiar_error = 1'b0;
        chk("dbl2_clr_estado", estado, 0);
        chk("dbl2_queue_empty", exp_q.size(), 0);

        // Backpressure with a pending word, then release
        salida_lista = 1'b0;
        send(8'h66, 3'd0, 1'b0, 1'b0, 8'h66, 4'hD, 1'b0);
        chk("bp_entrada_lista", entrada_lista, 0);
        set_word(8'hD2, 3'd0, 1'b0, 1'b0, 8'hD2, 4'hA, 1'b0);
        limpiar_error = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            limpiar_error = 1'b0;
            chk("bp_no_accept", last_in_xfer, 0);
            chk("bp_valid_held", salida_valida, 1);
            chk("bp_palabra_held", palabra_corregida, 8'h66);
            chk("bp_datos_held", datos_corregidos, 4'hD);
            chk("bp_entrada_lista", entrada_lista, 0);
            chk("bp_estado_lleno", estado, 1);
        end
        salida_lista = 1'b1;
        next_cycle();
        chk("bp_release_accept", last_in_xfer, 1);
        set_word(8'h87, 3'd0, 1'b0, 1'b0, 8'h87, 4'h1, 1'b0);
        next_cycle();
        chk("bp_second_accept", last_in_xfer, 1);
        idle_inputs();
        next_cycle();
        chk("bp_drained", salida_valida, 0);
        chk("bp_queue_empty", exp_q.size(), 0);

        // Reset while a corrected word is held
        salida_lista = 1'b0;
        send(8'hD6, 3'd3, 1'b1, 1'b0, 8'hD2, 4'hA, 1'b1);
        rst = 1'b1;
        next_cycle();
        chk("mid_rst_salida_valida", salida_valida, 0);
        chk("mid_rst_palabra", palabra_corregida, 0);
        chk("mid_rst_datos", datos_corregidos, 0);
        chk("mid_rst_err", error_corregido, 0);
        chk("mid_rst_entrada_lista", entrada_lista, 0);
        chk("mid_rst_cont_simples", cont_simples, 0);
        chk("mid_rst_cont_dobles", cont_dobles, 0);
        rst = 1'b0;
        salida_lista = 1'b1;
        next_cycle();

        // Saturation on the 2-bit counter instance
        for (int k = 1; k <= 5; k++) begin
            send(8'h76, 3'b101, 1'b1, 1'b0, 8'h66, 4'hD, 1'b1);
            next_cycle();
            chk("sat_cont_simples_w2", cs_s, (k < 3) ? k : 3);
            chk("sat_cont_simples_w8", cont_simples, k);
        end

        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
